// File: rtl/prbs31_pkg.sv
// Shared PRBS31 definitions (x^31 + x^28 + 1, Fibonacci form) for the generator and the checker.
package prbs31_pkg;

    localparam int PRBS_LEN = 31;
    localparam int TAP_A    = 30;
    localparam int TAP_B    = 27;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/prbs31_checker_if.sv
// Serial bit stream in, lock/error status out; the checker sits on the slave side.
interface prbs31_checker_if #(
    parameter int ERR_W = 16
);

    logic             data_in;
    logic             data_valid;
    logic             clear_cnt;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic             pol_inv;

    modport master (
        output data_in,
        output data_valid,
        output clear_cnt,
        input  locked,
        input  err_pulse,
        input  err_count,
        input  pol_inv
    );

    modport slave (
        input  data_in,
        input  data_valid,
        input  clear_cnt,
        output locked,
        output err_pulse,
        output err_count,
        output pol_inv
    );

endinterface

// File: rtl/prbs31_step.sv
// One PRBS31 step: predicted next bit and the shifted register with that bit (optionally inverted) appended.
module prbs31_step
    import prbs31_pkg::*;
(
    input  logic [PRBS_LEN-1:0] i_sr,
    input  logic                i_inv,
    output logic                o_pred,
    output logic [PRBS_LEN-1:0] o_next
);

    assign o_pred = i_sr[TAP_A] ^ i_sr[TAP_B];
    assign o_next = {i_sr[PRBS_LEN-2:0], o_pred ^ i_inv};

endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 serial checker: HUNT -> SYNC -> LOCKED flywheel, error counting and loss-of-lock windowing.
// Optional polarity detection of an inverted stream is built with PRBS31_POL_DETECT_EN.
module prbs31_checker
    import prbs31_pkg::*;
#(
    parameter int LOCK_CNT    = 64,
    parameter int WIN_LEN     = 1024,
    parameter int LOSS_THRESH = 16,
    parameter int ERR_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    prbs31_checker_if.slave   bus
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    state_t              r_state, w_state_n;
    logic [PRBS_LEN-1:0] r_sr, w_sr_n, w_fly;
    logic [4:0]          r_fill, w_fill_n;
    logic [MATCH_W-1:0]  r_match, w_match_n;
    logic [WIN_W-1:0]    r_win, w_win_n;
    logic [WERR_W-1:0]   r_werr, w_werr_n;
    logic [ERR_W-1:0]    r_err_count, w_err_count_n;
    logic                r_err_pulse, w_err_pulse_n;
    logic                r_locked;
    logic                w_pred, w_pol_inv, w_err;

`ifdef PRBS31_POL_DETECT_EN
    logic [MATCH_W-1:0]  r_inv_cnt, w_inv_cnt_n;
    logic                r_pol_inv, w_pol_inv_n;
    assign w_pol_inv = r_pol_inv;
`else
    assign w_pol_inv = 1'b0;
`endif

    prbs31_step u_step (
        .i_sr   (r_sr),
        .i_inv  (w_pol_inv),
        .o_pred (w_pred),
        .o_next (w_fly)
    );

    // In LOCKED the compare is against the flywheel bit, so a line error never corrupts the local register
    assign w_err = (bus.data_in != (w_pred ^ w_pol_inv));

    always_comb begin
        w_state_n     = r_state;
        w_sr_n        = r_sr;
        w_fill_n      = r_fill;
        w_match_n     = r_match;
        w_win_n       = r_win;
        w_werr_n      = r_werr;
        w_err_count_n = r_err_count;
        w_err_pulse_n = 1'b0;
`ifdef PRBS31_POL_DETECT_EN
        w_inv_cnt_n   = r_inv_cnt;
        w_pol_inv_n   = r_pol_inv;
`endif
        if (bus.data_valid) begin
            case (r_state)
                HUNT: begin
                    w_sr_n   = {r_sr[PRBS_LEN-2:0], bus.data_in};
                    w_fill_n = r_fill + 5'd1;
                    if (r_fill == 5'(PRBS_LEN - 1)) begin
                        w_state_n = SYNC;
                        w_fill_n  = '0;
                        w_match_n = '0;
`ifdef PRBS31_POL_DETECT_EN
                        w_inv_cnt_n = '0;
`endif
                    end
                end
                SYNC: begin
                    w_sr_n = {r_sr[PRBS_LEN-2:0], bus.data_in};
                    // An all-zero register predicts zeros forever; never let that count toward lock
                    if (r_sr == '0) begin
                        w_match_n = '0;
`ifdef PRBS31_POL_DETECT_EN
                        w_inv_cnt_n = '0;
`endif
                    end else if (bus.data_in == w_pred) begin
                        w_match_n = r_match + MATCH_W'(1);
`ifdef PRBS31_POL_DETECT_EN
                        w_inv_cnt_n = '0;
                        w_pol_inv_n = 1'b0;
`endif
                        if (r_match == MATCH_W'(LOCK_CNT - 1)) begin
                            w_state_n = LOCKED;
                            w_win_n   = '0;
                            w_werr_n  = '0;
                        end
                    end else begin
                        w_match_n = '0;
`ifdef PRBS31_POL_DETECT_EN
                        w_inv_cnt_n = r_inv_cnt + MATCH_W'(1);
                        if (r_inv_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                            w_state_n   = LOCKED;
                            w_pol_inv_n = 1'b1;
                            w_win_n     = '0;
                            w_werr_n    = '0;
                        end
`endif
                    end
                end
                LOCKED: begin
                    w_sr_n = w_fly;
                    if (w_err) begin
                        w_err_pulse_n = 1'b1;
                        w_err_count_n = sat_inc(r_err_count);
                        w_werr_n      = r_werr + WERR_W'(1);
                    end
                    if (r_win == WIN_W'(WIN_LEN - 1)) begin
                        w_win_n  = '0;
                        w_werr_n = '0;
                    end else begin
                        w_win_n = r_win + WIN_W'(1);
                    end
                    // The loss test sees the current error even when it is the last bit of the window
                    if (w_err && (r_werr == WERR_W'(LOSS_THRESH - 1))) begin
                        w_state_n = HUNT;
                        w_fill_n  = '0;
`ifdef PRBS31_POL_DETECT_EN
                        w_pol_inv_n = 1'b0;
`endif
                    end
                end
                default: begin
                    w_state_n = HUNT;
                    w_fill_n  = '0;
                end
            endcase
        end
        if (bus.clear_cnt) begin
            w_err_count_n = '0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state     <= HUNT;
            r_sr        <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_win       <= '0;
            r_werr      <= '0;
            r_err_count <= '0;
            r_err_pulse <= 1'b0;
            r_locked    <= 1'b0;
`ifdef PRBS31_POL_DETECT_EN
            r_inv_cnt   <= '0;
            r_pol_inv   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_n;
            r_sr        <= w_sr_n;
            r_fill      <= w_fill_n;
            r_match     <= w_match_n;
            r_win       <= w_win_n;
            r_werr      <= w_werr_n;
            r_err_count <= w_err_count_n;
            r_err_pulse <= w_err_pulse_n;
            r_locked    <= (w_state_n == LOCKED);
`ifdef PRBS31_POL_DETECT_EN
            r_inv_cnt   <= w_inv_cnt_n;
            r_pol_inv   <= w_pol_inv_n;
`endif
        end
    end

    assign bus.locked    = r_locked;
    assign bus.err_pulse = r_err_pulse;
    assign bus.err_count = r_err_count;
    assign bus.pol_inv   = w_pol_inv;

endmodule

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
- Serial PRBS31 receiver/checker. It is the far end of the team's PRBS31 generator.
- Polynomial x^31 + x^28 + 1, Fibonacci form, generator taps [30] and [27], MSB-first serial output.
- Self-synchronises to the incoming bit stream, declares lock, then free-runs a local flywheel LFSR. Counts bit errors and drops lock on excessive error density.
- Sits behind the pad/loopback path on the tile; status goes to uo_out.

Parameters:
- LOCK_CNT, 64: consecutive correct predictions required in SYNC before entering LOCKED.
- WIN_LEN, 1024: size of the loss-of-lock window, in valid bits.
- LOSS_THRESH, 16: errors within one window that force LOCKED -> HUNT.
- ERR_W, 16: width of the saturating error counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-high (rst_n=1 resets)
- data_in  in  1  received serial bit; sampled only when data_valid=1
- data_valid  in  1  bit-enable qualifier
- clear_cnt  in  1  synchronous clear of err_count
- locked  out  1  high in LOCKED
- err_pulse  out  1  one-cycle pulse per detected bit error (LOCKED only)
- err_count  out  ERR_W  saturating total error count
- pol_inv  out  1  locked to an inverted stream (see Optional Feature)

Behaviour:
- Reset (async, rst_n=1) clears all state:
  - sr=0, state=HUNT, fill=0, match_cnt=0, win_cnt=0, win_err=0.
  - Outputs locked=0, err_pulse=0, err_count=0, pol_inv=0.
- Shift register sr[30:0] shifts left on each valid bit; sr[0] takes the new bit. Predicted bit pred = sr[30]^sr[27].
- All logic advances only when data_valid=1. With data_valid=0, state is held and err_pulse=0.
- HUNT:
  - sr loads data_in; fill counts 0..30.
  - When fill reaches 30 on a valid bit: next state SYNC, match_cnt=0.
- SYNC:
  - sr loads data_in.
  - If sr==0: no compare, match_cnt=0. This guards against an all-zero false lock.
  - Otherwise, data_in==pred: match_cnt++. Mismatch: match_cnt=0, stay in SYNC.
  - match_cnt reaching LOCK_CNT-1 on a match: next state LOCKED. Clear win_cnt and win_err.
- LOCKED:
  - sr loads pred^pol_inv (flywheel), so a single line error is counted once.
  - Error = data_in != (pred^pol_inv).
  - On error: err_pulse=1 for the next cycle, err_count++ saturating at all-ones, win_err++.
  - win_cnt increments per valid bit. At win_cnt==WIN_LEN-1, both win_cnt and win_err reset to 0.
  - If win_err reaches LOSS_THRESH (including the current error): next state HUNT, fill=0, locked falls next cycle. err_count is kept.
- Latency: locked rises on the cycle after the LOCK_CNT-th matching valid bit. err_pulse is registered, 1 cycle after the erroneous bit is sampled.
- clear_cnt=1 zeroes err_count. If an error occurs in the same cycle, clear wins and the count becomes 0. err_pulse still fires.
- locked = (state==LOCKED), registered.
- An error on the last bit of a window counts in the current window before the window reset.

Optional Feature:
- Macro PRBS31_POL_DETECT_EN.
- Defined:
  - SYNC also keeps inv_cnt, counting bits where data_in == ~pred.
  - inv_cnt reaching LOCK_CNT locks with pol_inv=1. The flywheel and compare then use pred^1.
  - pol_inv clears on return to HUNT.
- Undefined: inv_cnt is absent and pol_inv is tied to 0. An inverted stream never locks.

Decomposition:
- Package prbs31_pkg:
  - PRBS_LEN=31, TAP_A=30, TAP_B=27.
  - State enum: HUNT=2'd0, SYNC=2'd1, LOCKED=2'd2.
- Sub-module prbs31_step: combinational next-bit function pred = sr[TAP_A]^sr[TAP_B]. Shared with the generator.
- Everything else stays in prbs31_checker.

Test Plan:
- Generator stream from seed 1, data_valid=1 always -> locked=1 exactly 31+64+1 cycles after reset release; err_count stays 0 over 10000 bits.
- Locked; flip one bit at bit index 5000 -> exactly one err_pulse, 1 cycle after that bit; err_count=1; locked stays 1.
- Locked; flip 16 bits within one 1024-bit window -> locked=0 on the cycle after the 16th error. Relock follows after 31+64 clean bits; err_count=16 is retained.
- Constant data_in=0 for 500 bits -> stays in SYNC, locked=0 throughout.
- data_valid toggling 1/0 every cycle -> lock reached after 95 valid bits (190 cycles). Assert rst_n=1 mid-lock -> all outputs 0 immediately (asynchronous).
- Inverted generator stream -> with PRBS31_POL_DETECT_EN: locked=1, pol_inv=1, err_count=0. Without it: locked stays 0.
